// File: rtl/dma_pkg.sv
// Shared DMA controller types: FSM state encoding, direction codes and
// the byte-count to word-count rounding helper.
package dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_M2P    = 3'd1,
    S_P2M_RD = 3'd2,
    S_P2M_WR = 3'd3,
    S_DONE   = 3'd4
  } dma_state_e;

  localparam logic [2:0] DMA_M2P = 3'b000;
  localparam logic [2:0] DMA_P2M = 3'b001;

  localparam int WCNT_W = 12;
  localparam int PADDR_W = 11;

  // Round a byte count up to whole 32-bit words (8191 bytes -> 2048 words).
  function automatic logic [WCNT_W-1:0] size_to_words(input logic [12:0] size);
    return WCNT_W'(({1'b0, size} + 14'd3) >> 2);
  endfunction

endpackage

// File: rtl/dma_ctrl.sv
// DMA engine moving word streams between data memory and a PIM bank.
// Build option DMA_PERF_CNT_EN adds dma_words_o, a saturating completed-word counter.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               dma_en_i,
  input  logic [2:0]         dma_funct3_i,
  input  logic [3:0]         dma_sel_pim_i,
  input  logic [12:0]        dma_size_i,
  input  logic [XLEN-1:0]    dma_mem_addr_i,
  output logic               dma_busy_o,
  output logic               req_dmem_o,
  input  logic               gnt_dmem_i,
  output logic [XLEN-1:0]    mem_addr_o,
  input  logic [XLEN-1:0]    mem_rd_data_i,
  output logic [XLEN-1:0]    mem_wr_data_o,
  output logic [3:0]         mem_size_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [3:0]         pim_sel_o,
  output logic [PADDR_W-1:0] pim_addr_o,
  output logic [XLEN-1:0]    pim_wr_data_o,
  output logic               pim_read_o,
  output logic               pim_write_o,
  input  logic [XLEN-1:0]    pim_rd_data_i
`ifdef DMA_PERF_CNT_EN
  ,
  output logic [31:0]        dma_words_o
`endif
);

  // state    | meaning
  // S_IDLE   | waiting for dma_en_i, command latched on strobe
  // S_M2P    | granted mem reads, each followed next cycle by a PIM write
  // S_P2M_RD | one-cycle PIM read of the current word
  // S_P2M_WR | mem write held with req_dmem_o until granted
  // S_DONE   | one cycle of completion, no bus activity

  dma_state_e          state_q, state_d;
  logic [XLEN-1:0]     addr_q;
  logic [PADDR_W-1:0]  paddr_q;
  logic [WCNT_W-1:0]   rem_q;
  logic [3:0]          sel_q;
  logic [XLEN-1:0]     hold_q;
  logic                wr_pend_q;
  logic                rd_vld_q;
  logic                busy_q;
  logic                latch_cmd;
  logic                word_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d       = state_q;
    latch_cmd     = 1'b0;
    req_dmem_o    = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    mem_size_o    = '0;
    pim_read_o    = 1'b0;
    pim_write_o   = 1'b0;
    pim_sel_o     = '0;
    pim_addr_o    = '0;
    pim_wr_data_o = '0;
    case (state_q)
      S_IDLE: begin
        if (dma_en_i) begin
          latch_cmd = 1'b1;
          if (dma_size_i == '0)
            state_d = S_DONE;
          else if (dma_funct3_i == DMA_M2P)
            state_d = S_M2P;
          else if (dma_funct3_i == DMA_P2M)
            state_d = S_P2M_RD;
          else
            state_d = S_DONE;
        end
      end
      S_M2P: begin
        req_dmem_o = 1'b1;
        pim_sel_o  = sel_q;
        if (gnt_dmem_i && rem_q != '0) begin
          mem_read_o = 1'b1;
          mem_addr_o = addr_q;
          mem_size_o = 4'b1111;
        end
        // The word read last cycle lands in PIM now, even if the grant dropped.
        if (wr_pend_q) begin
          pim_write_o   = 1'b1;
          pim_addr_o    = paddr_q;
          pim_wr_data_o = mem_rd_data_i;
        end
        if (rem_q == '0)
          state_d = S_DONE;
      end
      S_P2M_RD: begin
        pim_read_o = 1'b1;
        pim_sel_o  = sel_q;
        pim_addr_o = paddr_q;
        state_d    = S_P2M_WR;
      end
      S_P2M_WR: begin
        req_dmem_o    = 1'b1;
        mem_write_o   = 1'b1;
        mem_addr_o    = addr_q;
        mem_size_o    = 4'b1111;
        pim_sel_o     = sel_q;
        // PIM data is live on the first write cycle; later cycles use the held copy.
        mem_wr_data_o = rd_vld_q ? pim_rd_data_i : hold_q;
        if (gnt_dmem_i)
          state_d = (rem_q == WCNT_W'(1)) ? S_DONE : S_P2M_RD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign word_done  = pim_write_o | (mem_write_o & gnt_dmem_i);
  assign dma_busy_o = busy_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      paddr_q   <= '0;
      rem_q     <= '0;
      sel_q     <= '0;
      hold_q    <= '0;
      wr_pend_q <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else if (latch_cmd) begin
      addr_q    <= dma_mem_addr_i & ~XLEN'(3);
      paddr_q   <= '0;
      rem_q     <= size_to_words(dma_size_i);
      sel_q     <= dma_sel_pim_i;
      wr_pend_q <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      wr_pend_q <= mem_read_o;
      rd_vld_q  <= pim_read_o;
      if (rd_vld_q)
        hold_q <= pim_rd_data_i;
      if (mem_read_o || (mem_write_o && gnt_dmem_i)) begin
        addr_q <= addr_q + XLEN'(4);
        rem_q  <= rem_q - WCNT_W'(1);
      end
      if (word_done)
        paddr_q <= paddr_q + PADDR_W'(1);
    end
  end

`ifdef DMA_PERF_CNT_EN
  logic [31:0] words_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      words_q <= '0;
    else if (word_done && words_q != '1)
      words_q <= words_q + 32'd1;
  end

  assign dma_words_o = words_q;
`endif

endmodule
